// File: rtl/cc_arb_pkg.sv
// cc_arb_pkg: shared state encoding, mode constants and job layout for the job arbiter
package cc_arb_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SEND = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_RECV = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;
   localparam logic [1:0] MODE_ILLEGAL = 2'd3;
   localparam int NUM_PTS = 4;
   localparam int CRD_W = 8;
   typedef struct packed {
      logic [1:0]               mode;
      logic [NUM_PTS*CRD_W-1:0] x;
      logic [NUM_PTS*CRD_W-1:0] y;
   } job_t;
endpackage

// File: rtl/cc_rr_picker.sv
// cc_rr_picker: combinational round-robin grant, first valid requester at or after ptr
module cc_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int ID_W = 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any
);
   // scan offsets from farthest to nearest so the nearest valid one wins
   always_comb begin
      int j;
      j = 0;
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (valid[j]) idx = ID_W'(j);
      end
      any = |valid;
      grant = any ? NUM_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/cc_job_arbiter.sv
// cc_job_arbiter: round-robin sharing of one coordinate engine; CC_ARB_STATS_EN adds job/timeout counters
module cc_job_arbiter
   import cc_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W = 1,
   parameter int TIMEOUT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [2*NUM_REQ-1:0]  req_mode,
   input  logic [32*NUM_REQ-1:0] req_x,
   input  logic [32*NUM_REQ-1:0] req_y,
   output logic                  eng_in_valid,
   output logic [1:0]            eng_mode,
   output logic [7:0]            eng_xi,
   output logic [7:0]            eng_yi,
   input  logic                  eng_out_valid,
   input  logic [7:0]            eng_xo,
   input  logic [7:0]            eng_yo,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  rsp_last,
   output logic                  rsp_err,
   output logic [7:0]            rsp_xo,
   output logic [7:0]            rsp_yo
`ifdef CC_ARB_STATS_EN
  ,output logic [15:0]           stat_jobs,
   output logic [7:0]            stat_timeouts
`endif
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [2:0]         st;
   logic [1:0]         cnt;
   logic [WD_W-1:0]    wd;
   logic [ID_W-1:0]    rr_ptr, owner, g_idx;
   logic [NUM_REQ-1:0] g_oh;
   logic               g_any, timeout_hit, job_done;
   logic [1:0]         g_mode;
   logic [7:0]         buf_x, buf_y;
   job_t               job;

   cc_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .valid(req_valid),
      .ptr  (rr_ptr),
      .grant(g_oh),
      .idx  (g_idx),
      .any  (g_any)
   );

   // grant, engine drive and response beats all decode from the registered state and buffer
   always_comb begin
      g_mode = req_mode[{g_idx, 1'b0} +: 2];
      req_ready = (st == ST_IDLE) ? g_oh : '0;
      eng_in_valid = st == ST_SEND;
      eng_mode = eng_in_valid ? job.mode : '0;
      eng_xi = eng_in_valid ? job.x[{cnt, 3'b0} +: 8] : '0;
      eng_yi = eng_in_valid ? job.y[{cnt, 3'b0} +: 8] : '0;
      timeout_hit = st == ST_WAIT && !eng_out_valid && wd == WD_W'(TIMEOUT - 1);
      job_done = st == ST_RECV && !eng_out_valid;
      rsp_valid = st == ST_RECV || st == ST_ERR;
      rsp_id = rsp_valid ? owner : '0;
      rsp_err = st == ST_ERR;
      rsp_last = rsp_err || job_done;
      rsp_xo = (st == ST_RECV) ? buf_x : '0;
      rsp_yo = (st == ST_RECV) ? buf_y : '0;
   end

   // job FSM: capture on grant, stream 4 points, watch for the burst, skid it out one beat late
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st <= ST_IDLE;
         cnt <= '0;
         wd <= '0;
         rr_ptr <= '0;
         owner <= '0;
         job <= '0;
         buf_x <= '0;
         buf_y <= '0;
      end else begin
         case (st)
            ST_IDLE: if (g_any) begin
               job <= '{mode: g_mode, x: req_x[{g_idx, 5'b0} +: 32], y: req_y[{g_idx, 5'b0} +: 32]};
               owner <= g_idx;
               rr_ptr <= (g_idx == ID_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
               cnt <= '0;
               st <= (g_mode == MODE_ILLEGAL) ? ST_ERR : ST_SEND;
            end
            ST_SEND: begin
               cnt <= cnt + 2'd1;
               wd <= '0;
               if (cnt == 2'd3) st <= ST_WAIT;
            end
            ST_WAIT: begin
               wd <= wd + 1'b1;
               buf_x <= eng_xo;
               buf_y <= eng_yo;
               st <= eng_out_valid ? ST_RECV : timeout_hit ? ST_ERR : ST_WAIT;
            end
            ST_RECV: begin
               buf_x <= eng_out_valid ? eng_xo : buf_x;
               buf_y <= eng_out_valid ? eng_yo : buf_y;
               st <= eng_out_valid ? ST_RECV : ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

`ifdef CC_ARB_STATS_EN
   // saturating counters of good completions and watchdog expiries
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_jobs <= '0;
         stat_timeouts <= '0;
      end else begin
         stat_jobs <= stat_jobs + {15'd0, job_done && stat_jobs != 16'hFFFF};
         stat_timeouts <= stat_timeouts + {7'd0, timeout_hit && stat_timeouts != 8'hFF};
      end
   end
`endif
endmodule

// File: tb/tb_cc_job_arbiter.sv
// tb_cc_job_arbiter: directed checks of grant order, engine streaming, responses, errors and reset
module tb_cc_job_arbiter;
   logic       clk = 0, rst_n = 0;
   logic [1:0] req_valid, req_ready;
   logic [3:0] req_mode;
   logic [63:0] req_x, req_y;
   logic       eng_in_valid, eng_out_valid;
   logic [1:0] eng_mode;
   logic [7:0] eng_xi, eng_yi, eng_xo, eng_yo;
   logic       rsp_valid, rsp_id, rsp_last, rsp_err;
   logic [7:0] rsp_xo, rsp_yo;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   cc_job_arbiter #(.NUM_REQ(2), .ID_W(1), .TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_x(req_x), .req_y(req_y),
      .eng_in_valid(eng_in_valid), .eng_mode(eng_mode), .eng_xi(eng_xi), .eng_yi(eng_yi),
      .eng_out_valid(eng_out_valid), .eng_xo(eng_xo), .eng_yo(eng_yo),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .rsp_xo(rsp_xo), .rsp_yo(rsp_yo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rdy(input string tag, input logic [1:0] exp);
      chk(tag, 32'(req_ready), 32'(exp));
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic id, input logic last,
                          input logic err, input logic [7:0] xo, input logic [7:0] yo);
      chk(tag, 32'({rsp_valid, rsp_id, rsp_last, rsp_err, rsp_xo, rsp_yo}),
          32'({v, id, last, err, xo, yo}));
   endtask

   task automatic chk_eng(input string tag, input logic v, input logic [1:0] m,
                          input logic [7:0] xi, input logic [7:0] yi);
      chk(tag, 32'({eng_in_valid, eng_mode, eng_xi, eng_yi}), 32'({v, m, xi, yi}));
   endtask

   task automatic send4(input string tag, input logic [1:0] m, input logic [31:0] xw, input logic [31:0] yw);
      for (int p = 0; p < 4; p++) begin
         #1;
         chk_eng(tag, 1'b1, m, xw[8*p +: 8], yw[8*p +: 8]);
         chk_rdy({tag, "_busy"}, 2'b00);
         cyc();
      end
   endtask

   initial begin
      req_valid = 0; req_mode = 0; req_x = 0; req_y = 0;
      eng_out_valid = 0; eng_xo = 0; eng_yo = 0;
      cyc(); cyc();
      chk_rsp("reset_rsp", 0, 0, 0, 0, 8'h00, 8'h00);
      chk_eng("reset_eng", 0, 2'd0, 8'h00, 8'h00);
      chk_rdy("reset_ready", 2'b00);
      rst_n = 1;
      // single-beat mode 2 job from requester 0
      req_valid = 2'b01; req_mode = 4'b0010;
      req_x[31:0] = 32'h44332211; req_y[31:0] = 32'h88776655;
      #1 chk_rdy("t1_grant", 2'b01);
      cyc();
      req_valid = 0;
      send4("t1_send", 2'd2, 32'h44332211, 32'h88776655);
      #1 chk_eng("t1_wait_eng", 0, 2'd0, 8'h00, 8'h00);
      chk_rsp("t1_wait_rsp", 0, 0, 0, 0, 8'h00, 8'h00);
      cyc(); cyc();
      eng_out_valid = 1; eng_xo = 8'h00; eng_yo = 8'h10;
      cyc();
      eng_out_valid = 0; eng_yo = 8'h00;
      #1 chk_rsp("t1_rsp", 1, 0, 1, 0, 8'h00, 8'h10);
      cyc();
      #1 chk_rsp("t1_idle", 0, 0, 0, 0, 8'h00, 8'h00);
      // five-beat mode 0 burst for requester 1
      req_valid = 2'b10; req_mode = 4'b0000;
      req_x[63:32] = 32'hD4C3B2A1; req_y[63:32] = 32'h0F0E0D0C;
      #1 chk_rdy("t2_grant", 2'b10);
      cyc();
      req_valid = 0;
      send4("t2_send", 2'd0, 32'hD4C3B2A1, 32'h0F0E0D0C);
      eng_out_valid = 1; eng_xo = 8'd3; eng_yo = 8'd2;
      cyc();
      for (int k = 0; k < 5; k++) begin
         eng_out_valid = (k < 4);
         eng_xo = (k < 4) ? 8'(4 + k) : 8'd0;
         #1 chk_rsp("t2_rsp", 1, 1, k == 4, 0, 8'(3 + k), 8'd2);
         cyc();
      end
      #1 chk_rsp("t2_idle", 0, 0, 0, 0, 8'h00, 8'h00);
      // both requesters hold illegal jobs: grants alternate, no engine traffic
      req_valid = 2'b11; req_mode = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         #1 chk_rdy("t3_grant", (i % 2 == 1) ? 2'b10 : 2'b01);
         cyc();
         #1 chk_rsp("t3_err", 1, 1'(i % 2), 1, 1, 8'h00, 8'h00);
         chk_rdy("t3_busy", 2'b00);
         chk_eng("t3_noeng", 0, 2'd0, 8'h00, 8'h00);
         cyc();
      end
      // silent engine: watchdog error, then the queued requester is served
      req_mode = 4'b1101;
      #1 chk_rdy("t5_grant0", 2'b01);
      cyc();
      req_valid = 2'b10;
      send4("t5_send", 2'd1, 32'h44332211, 32'h88776655);
      for (int w = 0; w < 8; w++) begin
         #1 chk_rsp("t5_wait", 0, 0, 0, 0, 8'h00, 8'h00);
         chk_rdy("t5_wait_busy", 2'b00);
         cyc();
      end
      #1 chk_rsp("t5_timeout", 1, 0, 1, 1, 8'h00, 8'h00);
      cyc();
      #1 chk_rdy("t5_grant1", 2'b10);
      cyc();
      #1 chk_rsp("t5_next_err", 1, 1, 1, 1, 8'h00, 8'h00);
      req_valid = 0;
      cyc();
      // reset during SEND beat 2 abandons the job
      req_valid = 2'b01; req_mode = 4'b0010;
      #1 chk_rdy("t6_grant", 2'b01);
      cyc();
      req_valid = 0;
      #1 chk_eng("t6_beat0", 1, 2'd2, 8'h11, 8'h55);
      cyc();
      #1 chk_eng("t6_beat1", 1, 2'd2, 8'h22, 8'h66);
      cyc();
      rst_n = 0;
      #1 chk_eng("t6_beat2", 1, 2'd2, 8'h33, 8'h77);
      cyc();
      rst_n = 1;
      #1 chk_eng("t6_rst_eng", 0, 2'd0, 8'h00, 8'h00);
      chk_rsp("t6_rst_rsp", 0, 0, 0, 0, 8'h00, 8'h00);
      chk_rdy("t6_rst_ready", 2'b00);
      eng_out_valid = 1; eng_xo = 8'h55; eng_yo = 8'h66;
      cyc();
      eng_out_valid = 0;
      for (int i = 0; i < 6; i++) begin
         #1 chk_rsp("t6_quiet", 0, 0, 0, 0, 8'h00, 8'h00);
         cyc();
      end
      req_valid = 2'b11;
      #1 chk_rdy("t6_ptr_reset", 2'b01);
      req_valid = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
